// File: rtl/neuron_accum_ctrl_if.sv
// Signal bundle around the neuron accumulation sequencer: control, term stream,
// shared registered adder and result stream.
interface neuron_accum_ctrl_if #(
  parameter int unsigned ACC_W = 17,
  parameter int unsigned IN_W  = 8
);
  logic             start;
  logic [ACC_W-1:0] bias;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic [ACC_W-1:0] add_in1;
  logic [IN_W-1:0]  add_in2;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             busy;
  logic             overflow;

  // Sequencer side.
  modport slave (
    input  start, bias, in_valid, in_data, add_sum, add_carry, out_ready,
    output in_ready, add_in1, add_in2, out_valid, out_data, busy, overflow
  );

  // Environment side: term source, adder, result sink.
  modport master (
    output start, bias, in_valid, in_data, add_sum, add_carry, out_ready,
    input  in_ready, add_in1, add_in2, out_valid, out_data, busy, overflow
  );
endinterface

// File: rtl/neuron_accum_ctrl.sv
// Sequences one neuron pre-activation (bias + NUM_INPUTS signed terms) through a shared
// registered adder. Define NEURON_ACCUM_SATURATE_EN to clamp the accumulator on overflow.
module neuron_accum_ctrl #(
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned ACC_W      = 17,
  parameter int unsigned IN_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  neuron_accum_ctrl_if.slave bus
);

  localparam int unsigned CntW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_INPUTS - 1);
`ifdef NEURON_ACCUM_SATURATE_EN
  localparam logic [ACC_W-1:0] MaxVal = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MinVal = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StIssue,
    StCapture,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IN_W-1:0]  op_q, op_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ovf_now;

  // The adder carry carries no information for signed accumulation.
  logic unused_carry;
  assign unused_carry = bus.add_carry;

  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf_now = (acc_q[ACC_W-1] == op_q[IN_W-1]) &&
                   (bus.add_sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d   = bus.bias;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = StAccept;
        end
      end
      StAccept: begin
        if (bus.in_valid) begin
          op_d    = bus.in_data;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        acc_d = bus.add_sum;
        if (ovf_now) begin
          ovf_d = 1'b1;
`ifdef NEURON_ACCUM_SATURATE_EN
          acc_d = op_q[IN_W-1] ? MinVal : MaxVal;
`endif
        end
        if (count_q == LastCnt) begin
          state_d = StDone;
        end else begin
          count_d = count_q + CntW'(1);
          state_d = StAccept;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      op_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == StAccept);
    bus.add_in1   = (state_q == StIssue) ? acc_q : '0;
    bus.add_in2   = (state_q == StIssue) ? op_q : '0;
    bus.out_valid = (state_q == StDone);
    bus.out_data  = (state_q == StDone) ? acc_q : '0;
    bus.busy      = (state_q != StIdle);
    bus.overflow  = ovf_q;
  end

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// Self-checking bench for neuron_accum_ctrl: registered adder model, randomized gaps and
// backpressure, and an integer reference model of bias + sum with overflow tracking.
module tb_neuron_accum_ctrl;

  localparam int unsigned NumInputs = 4;
  localparam int unsigned AccW      = 17;
  localparam int unsigned InW       = 8;
  localparam int          AccMax    = 65535;
  localparam int          AccMin    = -65536;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  neuron_accum_ctrl_if #(.ACC_W(AccW), .IN_W(InW)) bus ();

  neuron_accum_ctrl #(
    .NUM_INPUTS(NumInputs),
    .ACC_W     (AccW),
    .IN_W      (InW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Shared adder: one-cycle registered sum of accumulator and sign-extended term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.add_sum   <= '0;
      bus.add_carry <= 1'b0;
    end else begin
      {bus.add_carry, bus.add_sum} <= {1'b0, bus.add_in1} +
                                      {1'b0, {(AccW-InW){bus.add_in2[InW-1]}}, bus.add_in2};
    end
  end

  int               terms[NumInputs];
  logic [AccW-1:0]  res_data;
  logic             res_ovf;
  int               model_res;
  bit               model_ovf;

  // Reference: exact integer sum, then wrap (or clamp) back into the accumulator range.
  function automatic void model_step(input int acc, input int t, output int nxt, output bit ovf);
    int s;
    logic [AccW-1:0] w;
    s   = acc + t;
    ovf = (s > AccMax) || (s < AccMin);
    w   = s[AccW-1:0];
    nxt = int'($signed(w));
`ifdef NEURON_ACCUM_SATURATE_EN
    if (ovf) nxt = (t < 0) ? AccMin : AccMax;
`endif
  endfunction

  task automatic run_eval(input int bias_v, input int max_gap, input int hold_cycles,
                          input bit misuse);
    int exp_acc;
    int nxt;
    int gap;
    int waited;
    bit step_ovf;
    logic [AccW-1:0] held;
    exp_acc = bias_v;
    model_ovf = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bias  = AccW'(bias_v);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bias  = AccW'($urandom);
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1 || bus.overflow !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL start_accept: busy=%b overflow=%b in_ready=%b, required 1/0/1",
               bus.busy, bus.overflow, bus.in_ready);
    if (bus.busy !== 1'b1 || bus.overflow !== 1'b0 || bus.in_ready !== 1'b1) tests_failed++;
    @(posedge clk); #1;
    for (int i = 0; i < NumInputs; i++) begin
      gap = int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = InW'($urandom);
        if (misuse) begin
          bus.start = 1'b1;
          bus.bias  = AccW'($urandom);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = InW'(terms[i]);
      waited = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL handshake%0d: in_ready=%b after %0d cycles, required 1", i, bus.in_ready,
                 waited);
      end
      @(posedge clk); #1;
      bus.in_data  = InW'($urandom);
      bus.in_valid = (max_gap == 0) ? 1'b1 : 1'($urandom);
      if (misuse) begin
        bus.start = 1'b1;
        bus.bias  = AccW'($urandom);
      end
      @(negedge clk);
      tests_run++;
      if (bus.add_in1 !== AccW'(exp_acc) || bus.add_in2 !== InW'(terms[i]) ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL issue%0d: add_in1=%0d add_in2=%0d in_ready=%b out_valid=%b, required %0d/%0d/0/0",
                 i, $signed(bus.add_in1), $signed(bus.add_in2), bus.in_ready, bus.out_valid,
                 exp_acc, terms[i]);
      end
      model_step(exp_acc, terms[i], nxt, step_ovf);
      exp_acc = nxt;
      model_ovf = model_ovf | step_ovf;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.add_in1 !== '0 || bus.add_in2 !== '0 || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL capture%0d: add_in1=%0d add_in2=%0d in_ready=%b out_valid=%b busy=%b, required 0/0/0/0/1",
                 i, $signed(bus.add_in1), $signed(bus.add_in2), bus.in_ready, bus.out_valid,
                 bus.busy);
      end
      @(posedge clk); #1;
    end
    model_res = exp_acc;
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency: out_valid=%b 3 cycles after last handshake, required 1",
               bus.out_valid);
    end
    held = bus.out_data;
    for (int h = 0; h < hold_cycles; h++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      if (misuse) begin
        bus.start = 1'b1;
        bus.bias  = AccW'($urandom);
      end
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
        tests_failed++;
        $display("FAIL hold%0d: out_valid=%b out_data=%0d, required 1/%0d", h, bus.out_valid,
                 $signed(bus.out_data), $signed(held));
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.start     = misuse;
    bus.bias      = AccW'($urandom);
    @(negedge clk);
    res_data = bus.out_data;
    res_ovf  = bus.overflow;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== model_ovf) begin
      tests_failed++;
      $display("FAIL after_out: out_valid=%b busy=%b overflow=%b, required 0/0/%b",
               bus.out_valid, bus.busy, bus.overflow, model_ovf);
    end
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_stays: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
        bus.add_in1 !== '0 || bus.add_in2 !== '0 || bus.busy !== 1'b0 ||
        bus.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%0d add_in1=%0d add_in2=%0d busy=%b overflow=%b, required all 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.add_in1, bus.add_in2, bus.busy,
               bus.overflow);
    end
    #9 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_start: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    terms = '{27, -20, 50, -1};
    run_eval(100, 0, 0, 1'b0);
    tests_run++;
    if (res_data !== AccW'(156) || res_ovf !== 1'b0 || model_res != 156) begin
      tests_failed++;
      $display("FAIL basic: out_data=%0d overflow=%b, required 156/0", $signed(res_data),
               res_ovf);
    end
  endtask

  task automatic test_overflow();
    logic [AccW-1:0] exp_v;
    terms = '{1, 0, 0, 0};
    run_eval(65535, 0, 0, 1'b0);
`ifdef NEURON_ACCUM_SATURATE_EN
    exp_v = AccW'(65535);
`else
    exp_v = AccW'(-65536);
`endif
    tests_run++;
    if (res_data !== exp_v || res_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL pos_overflow: out_data=%0d overflow=%b, required %0d/1", $signed(res_data),
               res_ovf, $signed(exp_v));
    end
    terms = '{-128, 0, 0, 0};
    run_eval(-65408, 0, 0, 1'b0);
    tests_run++;
    if (res_data !== AccW'(-65536) || res_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL neg_boundary: out_data=%0d overflow=%b, required -65536/0",
               $signed(res_data), res_ovf);
    end
    terms = '{-1, 0, 0, 0};
    run_eval(-65536, 0, 0, 1'b0);
`ifdef NEURON_ACCUM_SATURATE_EN
    exp_v = AccW'(-65536);
`else
    exp_v = AccW'(65535);
`endif
    tests_run++;
    if (res_data !== exp_v || res_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL neg_overflow: out_data=%0d overflow=%b, required %0d/1", $signed(res_data),
               res_ovf, $signed(exp_v));
    end
  endtask

  task automatic test_backpressure();
    int b;
    terms = '{27, -20, 50, -1};
    run_eval(100, 5, 5, 1'b0);
    tests_run++;
    if (res_data !== AccW'(156) || res_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure: out_data=%0d overflow=%b, required 156/0", $signed(res_data),
               res_ovf);
    end
    for (int r = 0; r < 4; r++) begin
      b = int'($urandom_range(131071, 0)) - 65536;
      for (int i = 0; i < NumInputs; i++) terms[i] = int'($urandom_range(255, 0)) - 128;
      run_eval(b, 3, int'($urandom_range(3, 0)), 1'b0);
      tests_run++;
      if (res_data !== AccW'(model_res) || res_ovf !== model_ovf) begin
        tests_failed++;
        $display("FAIL random%0d: out_data=%0d overflow=%b, required %0d/%b", r,
                 $signed(res_data), res_ovf, model_res, model_ovf);
      end
    end
  endtask

  task automatic test_misuse();
    terms = '{27, -20, 50, -1};
    run_eval(100, 2, 3, 1'b1);
    tests_run++;
    if (res_data !== AccW'(156) || res_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL misuse: out_data=%0d overflow=%b, required 156/0", $signed(res_data),
               res_ovf);
    end
  endtask

  task automatic test_reset_midop();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bias  = AccW'(1000);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = InW'(10);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (i == 0) begin
        @(posedge clk); #1;
      end
    end
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_busy: busy=%b before reset, required 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_data !== '0 || bus.add_in1 !== '0 || bus.add_in2 !== '0 ||
        bus.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_reset: busy=%b in_ready=%b out_valid=%b out_data=%0d add_in1=%0d add_in2=%0d overflow=%b, required all 0",
               bus.busy, bus.in_ready, bus.out_valid, bus.out_data, bus.add_in1, bus.add_in2,
               bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    terms = '{1, 1, 1, 1};
    run_eval(5, 1, 1, 1'b0);
    tests_run++;
    if (res_data !== AccW'(9) || res_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_eval: out_data=%0d overflow=%b, required 9/0", $signed(res_data),
               res_ovf);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    bus.start     = 1'b0;
    bus.bias      = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_misuse();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
